// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - D-stage branch resolve with 2-bit saturating direction predictor
module branch_predict_unit #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      f_pc,
    input  logic             f_is_cbr,
    output logic             f_pred_taken,
    input  logic             d_valid,
    input  logic             d_stall,
    input  logic [31:0]      d_pc,
    input  logic [2:0]       branch,
    input  logic             d_pred_taken,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    output logic [2:0]       PC_sel,
    output logic             flush,
    output logic             bw,
    output logic             mispredict,
    output logic [CNT_W-1:0] stat_br,
    output logic [CNT_W-1:0] stat_miss
);

    localparam int ENTRIES = 2 ** IDX_W;

    localparam logic [2:0] BR_NONE   = 3'd0;
    localparam logic [2:0] BR_BEQ    = 3'd1;
    localparam logic [2:0] BR_J      = 3'd2;
    localparam logic [2:0] BR_JR     = 3'd3;
    localparam logic [2:0] BR_BNE    = 3'd4;
    localparam logic [2:0] BR_LIKELY = 3'd5;
    localparam logic [2:0] BR_BLTZ   = 3'd6;
    localparam logic [2:0] BR_BGEZ   = 3'd7;

    localparam logic [2:0] SEL_SEQ     = 3'b000;
    localparam logic [2:0] SEL_TARGET  = 3'b001;
    localparam logic [2:0] SEL_JUMP    = 3'b010;
    localparam logic [2:0] SEL_JR      = 3'b011;
    localparam logic [2:0] SEL_LIKELY  = 3'b100;
    localparam logic [2:0] SEL_RECOVER = 3'b101;

    logic [1:0]       cnt_tbl [ENTRIES];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic             eq;
    logic             neg;
    logic             taken;
    logic             cond;
    logic             active;
    logic             update;
    logic             unused_pc_bits;

    assign f_idx = f_pc[IDX_W+1:2];
    assign d_idx = d_pc[IDX_W+1:2];

    // Only the index field of each PC addresses the table; no tags are kept.
    assign unused_pc_bits = ^{f_pc[31:IDX_W+2], f_pc[1:0], d_pc[31:IDX_W+2], d_pc[1:0]};

    assign f_pred_taken = f_is_cbr & cnt_tbl[f_idx][1];

    assign eq     = (RD1 == RD2);
    assign neg    = RD1[WIDTH-1];
    assign active = d_valid & ~d_stall;
    assign update = cond & ~d_stall;

    // Resolve branch direction and whether the D instruction is a conditional branch.
    always_comb begin
        taken = 1'b0;
        cond  = 1'b0;
        case (branch)
            BR_BEQ:    begin taken = eq;   cond = d_valid; end
            BR_BNE:    begin taken = ~eq;  cond = d_valid; end
            BR_LIKELY: begin taken = eq;   cond = d_valid; end
            BR_BLTZ:   begin taken = neg;  cond = d_valid; end
            BR_BGEZ:   begin taken = ~neg; cond = d_valid; end
            default:   begin taken = 1'b0; cond = 1'b0;    end
        endcase
    end

    assign mispredict = update & (taken != d_pred_taken);

    // Select the next fetch PC and the wrong-path / delay-slot kill.
    always_comb begin
        PC_sel = SEL_SEQ;
        flush  = 1'b0;
        bw     = 1'b0;
        if (active) begin
            case (branch)
                BR_NONE: PC_sel = SEL_SEQ;
                BR_J:    PC_sel = SEL_JUMP;
                BR_JR:   PC_sel = SEL_JR;
                BR_LIKELY: begin
                    PC_sel = taken ? SEL_LIKELY : SEL_SEQ;
                    bw     = eq;
                end
                default: begin
                    if (mispredict)
                        PC_sel = taken ? SEL_TARGET : SEL_RECOVER;
                    else
                        PC_sel = SEL_SEQ;
                end
            endcase
            flush = mispredict | ((branch == BR_LIKELY) & ~eq);
        end
    end

    // Train the resolved branch's counter and count statistics; reset beats any update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_tbl[i] <= 2'b01;
            stat_br   <= '0;
            stat_miss <= '0;
        end else if (update) begin
            if (taken) begin
                if (cnt_tbl[d_idx] != 2'b11)
                    cnt_tbl[d_idx] <= cnt_tbl[d_idx] + 2'd1;
            end else begin
                if (cnt_tbl[d_idx] != 2'b00)
                    cnt_tbl[d_idx] <= cnt_tbl[d_idx] - 2'd1;
            end
            stat_br <= stat_br + CNT_W'(1);
            if (mispredict)
                stat_miss <= stat_miss + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   f_pc;
    logic          f_is_cbr;
    logic          f_pred_taken;
    logic          d_valid;
    logic          d_stall;
    logic [31:0]   d_pc;
    logic [2:0]    branch;
    logic          d_pred_taken;
    logic [31:0]   RD1;
    logic [31:0]   RD2;
    logic [2:0]    PC_sel;
    logic          flush;
    logic          bw;
    logic          mispredict;
    logic [CW-1:0] stat_br;
    logic [CW-1:0] stat_miss;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          pred;
        logic [2:0]    pc_sel;
        logic          flush;
        logic          bw;
        logic          misp;
        logic [CW-1:0] sbr;
        logic [CW-1:0] smiss;
    } exp_t;

    exp_t sb[$];

    logic [1:0]    m_cnt [64];
    logic [CW-1:0] m_br;
    logic [CW-1:0] m_miss;

    branch_predict_unit #(.WIDTH(32), .IDX_W(6), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_is_cbr(f_is_cbr),
        .f_pred_taken(f_pred_taken), .d_valid(d_valid), .d_stall(d_stall),
        .d_pc(d_pc), .branch(branch), .d_pred_taken(d_pred_taken),
        .RD1(RD1), .RD2(RD2), .PC_sel(PC_sel), .flush(flush), .bw(bw),
        .mispredict(mispredict), .stat_br(stat_br), .stat_miss(stat_miss)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
        m_br   = '0;
        m_miss = '0;
    endtask

    task automatic step(input logic rst, input logic [31:0] fpc, input logic fcbr,
                        input logic dv, input logic ds, input logic [31:0] dpc,
                        input logic [2:0] br, input logic dpred,
                        input logic [31:0] rd1, input logic [31:0] rd2);
        exp_t e;
        exp_t got;
        logic eq, neg, tk, isc, act;
        reset = rst; f_pc = fpc; f_is_cbr = fcbr; d_valid = dv; d_stall = ds;
        d_pc = dpc; branch = br; d_pred_taken = dpred; RD1 = rd1; RD2 = rd2;

        eq  = (rd1 == rd2);
        neg = rd1[31];
        case (br)
            3'd1, 3'd5: tk = eq;
            3'd4:       tk = !eq;
            3'd6:       tk = neg;
            3'd7:       tk = !neg;
            default:    tk = 1'b0;
        endcase
        isc = dv && (br == 3'd1 || br >= 3'd4);
        act = dv && !ds;
        e.pred  = fcbr && m_cnt[fpc[7:2]][1];
        e.misp  = isc && !ds && (tk != dpred);
        e.pc_sel = 3'b000;
        if (act) begin
            if (br == 3'd2) e.pc_sel = 3'b010;
            else if (br == 3'd3) e.pc_sel = 3'b011;
            else if (br == 3'd5) e.pc_sel = tk ? 3'b100 : 3'b000;
            else if (isc && e.misp) e.pc_sel = tk ? 3'b001 : 3'b101;
        end
        e.flush = e.misp || (act && br == 3'd5 && !eq);
        e.bw    = act && br == 3'd5 && eq;
        e.sbr   = m_br;
        e.smiss = m_miss;
        sb.push_back(e);

        @(negedge clk);
        got = sb.pop_front();
        check_val("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, got.pred});
        check_val("PC_sel", {29'd0, PC_sel}, {29'd0, got.pc_sel});
        check_val("flush", {31'd0, flush}, {31'd0, got.flush});
        check_val("bw", {31'd0, bw}, {31'd0, got.bw});
        check_val("mispredict", {31'd0, mispredict}, {31'd0, got.misp});
        check_val("stat_br", {28'd0, stat_br}, {28'd0, got.sbr});
        check_val("stat_miss", {28'd0, stat_miss}, {28'd0, got.smiss});

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (isc && !ds) begin
            if (tk && m_cnt[dpc[7:2]] != 2'b11) m_cnt[dpc[7:2]] = m_cnt[dpc[7:2]] + 2'd1;
            if (!tk && m_cnt[dpc[7:2]] != 2'b00) m_cnt[dpc[7:2]] = m_cnt[dpc[7:2]] - 2'd1;
            m_br = m_br + 1'b1;
            if (e.misp) m_miss = m_miss + 1'b1;
        end
        #1;
    endtask

    localparam logic [31:0] PA = 32'h0000_0100;
    localparam logic [31:0] PB = 32'h0000_0204;
    localparam logic [31:0] PC = 32'h0000_1104;

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] vals [4];
        pcs[0] = PA; pcs[1] = PB; pcs[2] = PC; pcs[3] = 32'h0000_0010;
        vals[0] = 32'd0; vals[1] = 32'd5; vals[2] = 32'h8000_0000; vals[3] = 32'hFFFF_FFFF;

        reset = 1'b1; f_pc = '0; f_is_cbr = 1'b0; d_valid = 1'b0; d_stall = 1'b0;
        d_pc = '0; branch = '0; d_pred_taken = 1'b0; RD1 = '0; RD2 = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // post-reset: weak not-taken everywhere
        step(0, PA, 1, 0, 0, 0, 3'd0, 0, 0, 0);
        step(0, 32'hFFFF_FFFC, 1, 0, 0, 0, 3'd0, 0, 0, 0);
        // beq taken, predicted not-taken; F on same pc sees old counter
        step(0, PA, 1, 1, 0, PA, 3'd1, 0, 5, 5);
        step(0, PA, 1, 0, 0, 0, 3'd0, 0, 0, 0);
        // bne at PB: taken, taken, not-taken
        step(0, PB, 1, 1, 0, PB, 3'd4, 0, 1, 2);
        step(0, PB, 1, 1, 0, PB, 3'd4, 1, 1, 2);
        step(0, PB, 1, 1, 0, PB, 3'd4, 1, 3, 3);
        // bltz negative predicted taken, bgez zero
        step(0, PC, 1, 1, 0, PC, 3'd6, 1, 32'h8000_0000, 0);
        step(0, PC, 1, 1, 0, PC, 3'd7, 0, 0, 0);
        // beq-likely not-taken then taken
        step(0, PA, 1, 1, 0, PA, 3'd5, 0, 1, 2);
        step(0, PA, 1, 1, 0, PA, 3'd5, 1, 7, 7);
        // j, jr, invalid branch
        step(0, PA, 0, 1, 0, PA, 3'd2, 0, 1, 2);
        step(0, PA, 0, 1, 0, PA, 3'd3, 0, 1, 2);
        step(0, PA, 1, 0, 0, PA, 3'd1, 0, 5, 5);
        // stalled mispredicting beq: nothing happens
        step(0, PC, 1, 1, 1, PC, 3'd1, 0, 9, 9);
        step(0, PC, 1, 0, 0, 0, 3'd0, 0, 0, 0);
        // reset while a branch resolves
        step(1, PA, 1, 1, 0, PA, 3'd1, 0, 5, 5);
        step(0, PA, 1, 0, 0, 0, 3'd0, 0, 0, 0);
        // saturation and stat wrap
        for (int i = 0; i < 20; i++)
            step(0, PA, 1, 1, 0, PA, 3'd1, i[0], 4, 4);
        for (int i = 0; i < 6; i++)
            step(0, PA, 1, 1, 0, PA, 3'd4, 0, 4, 4);

        // random mix with aliasing PCs
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), pcs[$urandom_range(0, 3)], 1'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 pcs[$urandom_range(0, 3)], 3'($urandom), 1'($urandom),
                 vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)]);
        end

        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
